// File: rtl/mem_align_unit.sv
// mem_align_unit: splits misaligned LW/LH/LHU/SW/SH accesses into little-endian byte accesses
// Ports: req_* is the MEM-stage access; stall holds the pipeline while a split is in flight;
//   resp_valid/resp_rdata/resp_fault report completion; misalign_count counts misaligned starts
//   (saturating); mem_* drive the data memory and mem_rd is its read data.
// Option: define MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting them.
module mem_align_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_fault,
  output logic [15:0]           misalign_count,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state_q, state_d;
  logic [1:0] k_q, k_d, lastk;
  logic [DATA_W-1:0] acc_q, acc_d, asm_w, ext_w;
  logic [15:0] cnt_q, cnt_d;
  logic ld, st, w4, mis, start;
  assign ld = req_read;
  assign st = req_write & ~req_read;
  assign w4 = req_funct3 == 3'b010;
  assign mis = req_valid & (ld | st) &
               ((w4 & |req_addr[1:0]) | ((req_funct3 == 3'b001 | req_funct3 == 3'b101) & req_addr[0]));
  assign lastk = w4 ? 2'd3 : 2'd1;
  assign misalign_count = cnt_q;
  // Accumulator with the byte arriving this cycle merged in at lane k.
  always_comb begin
    asm_w = acc_q;
    asm_w[{k_q, 3'b000} +: 8] = mem_rd[7:0];
  end
  assign ext_w = w4 ? asm_w : {{(DATA_W-16){req_funct3 == 3'b001 & asm_w[15]}}, asm_w[15:0]};
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    start      = 1'b0;
    mem_a      = req_addr;
    mem_wd     = req_wdata;
    mem_funct3 = req_funct3;
    mem_read   = req_valid & ld;
    mem_write  = req_valid & st;
    stall      = 1'b0;
    resp_valid = req_valid;
    resp_rdata = mem_rd;
    resp_fault = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (mis) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      resp_fault = 1'b1;
      resp_rdata = '0;
      start      = 1'b1;
    end
`else
    // k_q is 0 whenever the FSM is idle, so cycle 0 shares the split datapath.
    if (state_q == SPLIT || mis) begin
      mem_a      = req_addr + DM_ADDRESS'(k_q);
      mem_wd     = DATA_W'(req_wdata[{k_q, 3'b000} +: 8]);
      mem_funct3 = {ld, 2'b00};
      stall      = 1'b1;
      resp_valid = 1'b0;
      resp_rdata = ext_w;
      acc_d      = asm_w;
      if (!req_valid) begin
        stall   = 1'b0;
        state_d = IDLE;
        k_d     = 2'd0;
      end else if (state_q == IDLE) begin
        state_d = SPLIT;
        k_d     = 2'd1;
        start   = 1'b1;
      end else if (k_q == lastk) begin
        stall      = 1'b0;
        resp_valid = 1'b1;
        state_d    = IDLE;
        k_d        = 2'd0;
      end else begin
        k_d = k_q + 2'd1;
      end
    end
`endif
    if (start && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      stall      = 1'b0;
      resp_valid = 1'b0;
      resp_fault = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_align_unit.sv
// tb_mem_align_unit: randomized check of mem_align_unit against a byte-array reference model
module tb_mem_align_unit;
  logic clk = 1'b0;
  logic reset, req_valid, req_read, req_write;
  logic [8:0] req_addr;
  logic [2:0] req_funct3;
  logic [31:0] req_wdata;
  logic stall, resp_valid, resp_fault, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_wd, mem_rd, mw;
  logic [15:0] misalign_count;
  logic [8:0] mem_a;
  logic [2:0] mem_funct3;
  logic [7:0] dmem [512];
  logic [7:0] ref_mem [512];
  logic poke_en = 1'b0;
  logic [8:0] poke_a;
  logic [31:0] poke_w;
  logic [31:0] last_rd;
  int n_chk = 0, n_err = 0, cnt_m = 0;

  always #5 clk = ~clk;

  mem_align_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .misalign_count(misalign_count), .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  always_comb begin
    logic [8:0] a1, a2, a3;
    a1 = mem_a + 9'd1;
    a2 = mem_a + 9'd2;
    a3 = mem_a + 9'd3;
    mw = {dmem[a3], dmem[a2], dmem[a1], dmem[mem_a]};
    mem_rd = mem_funct3 == 3'b000 ? {{24{mw[7]}}, mw[7:0]} :
             mem_funct3 == 3'b100 ? {24'd0, mw[7:0]} :
             mem_funct3 == 3'b001 ? {{16{mw[15]}}, mw[15:0]} :
             mem_funct3 == 3'b101 ? {16'd0, mw[15:0]} : mw;
  end

  always @(posedge clk) begin
    if (poke_en) begin
      for (int i = 0; i < 4; i++) dmem[poke_a + 9'(i)] <= poke_w[8*i +: 8];
    end else if (mem_write) begin
      dmem[mem_a] <= mem_wd[7:0];
      if (mem_funct3[1:0] != 2'd0) dmem[mem_a + 9'd1] <= mem_wd[15:8];
      if (mem_funct3[1:0] == 2'd2) begin
        dmem[mem_a + 9'd2] <= mem_wd[23:16];
        dmem[mem_a + 9'd3] <= mem_wd[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [31:0] w);
    poke_en = 1'b1;
    poke_a = a;
    poke_w = w;
    for (int i = 0; i < 4; i++) ref_mem[a + 9'(i)] = w[8*i +: 8];
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic rd, input logic wr, input logic [8:0] a, input logic [2:0] f3,
                      input logic [31:0] wd);
    logic mis;
    logic [31:0] exp;
    int n, sz;
    sz = f3[1:0] == 2'd2 ? 4 : f3[1:0] == 2'd1 ? 2 : 1;
    mis = (rd || wr) && ((f3 == 3'b010 && a % 4 != 0) || ((f3 == 3'b001 || f3 == 3'b101) && a % 2 != 0));
    n = mis ? sz : 1;
    exp = 0;
    for (int i = 0; i < sz; i++) exp |= 32'(ref_mem[(int'(a) + i) % 512]) << (8 * i);
    if (sz < 4 && !f3[2] && exp[8*sz-1]) exp |= 32'hFFFF_FFFF << (8 * sz);
    req_valid = 1'b1;
    req_read = rd;
    req_write = wr;
    req_addr = a;
    req_funct3 = f3;
    req_wdata = wd;
`ifdef MISALIGN_TRAP_EN
    if (mis) begin
      @(negedge clk);
      chk("trap_fault", 32'(resp_fault), 1);
      chk("trap_stall", 32'(stall), 0);
      chk("trap_valid", 32'(resp_valid), 1);
      chk("trap_rdata", resp_rdata, 0);
      chk("trap_memrw", {30'd0, mem_read, mem_write}, 0);
      tick();
      req_valid = 1'b0;
      if (cnt_m < 65535) cnt_m++;
      chk("count", 32'(misalign_count), cnt_m);
      last_rd = 0;
      return;
    end
`endif
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("mem_a", 32'(mem_a), (int'(a) + c) % 512);
      chk("mem_funct3", 32'(mem_funct3), mis ? {29'd0, rd, 2'b00} : 32'(f3));
      chk("stall", 32'(stall), 32'(c < n - 1));
      chk("resp_valid", 32'(resp_valid), 32'(c == n - 1));
      chk("resp_fault", 32'(resp_fault), 0);
      chk("mem_rw", {30'd0, mem_read, mem_write}, {30'd0, rd, !rd && wr});
      if (c == n - 1 && rd) begin
        chk("rdata", resp_rdata, exp);
        last_rd = resp_rdata;
      end
      tick();
    end
    req_valid = 1'b0;
    if (mis && cnt_m < 65535) cnt_m++;
    chk("count", 32'(misalign_count), cnt_m);
    if (!rd && wr) for (int i = 0; i < sz; i++) ref_mem[(int'(a) + i) % 512] = wd[8*i +: 8];
  endtask

  initial begin
    logic [2:0] lf3 [5];
    int bad;
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset = 1'b1;
    req_valid = 1'b1;
    req_read = 1'b1;
    req_write = 1'b0;
    req_addr = 9'h011;
    req_funct3 = 3'b010;
    req_wdata = 32'd0;
    @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 512; i += 4) poke(9'(i), $urandom);
    poke(9'h010, 32'h44332211);
    poke(9'h014, 32'h88776655);
    poke(9'h018, 32'h000000CC);
    reset = 1'b0;
    chk("rst_count", 32'(misalign_count), 0);

    xact(1, 0, 9'h011, 3'b010, 0);
`ifndef MISALIGN_TRAP_EN
    chk("plan_lw", last_rd, 32'h55443322);
`endif
    xact(1, 0, 9'h017, 3'b001, 0);
`ifndef MISALIGN_TRAP_EN
    chk("plan_lh", last_rd, 32'hFFFFCC88);
`endif
    xact(1, 0, 9'h017, 3'b101, 0);
`ifndef MISALIGN_TRAP_EN
    chk("plan_lhu", last_rd, 32'h0000CC88);
`endif
    xact(0, 1, 9'h012, 3'b010, 32'hAABBCCDD);
    xact(1, 0, 9'h010, 3'b010, 0);
`ifndef MISALIGN_TRAP_EN
    chk("plan_sw_lo", last_rd, 32'hCCDD2211);
`endif
    xact(1, 0, 9'h014, 3'b010, 0);
`ifndef MISALIGN_TRAP_EN
    chk("plan_sw_hi", last_rd, 32'h8877AABB);
`endif
    xact(1, 0, 9'h1FF, 3'b010, 0);
    xact(1, 1, 9'h0A3, 3'b001, 32'h12345678);
    xact(0, 1, 9'h1FF, 3'b001, 32'h0000BEEF);

    req_valid = 1'b1;
    req_read = 1'b1;
    req_write = 1'b0;
    req_addr = 9'h013;
    req_funct3 = 3'b011;
    @(negedge clk);
    chk("f3_011_stall", 32'(stall), 0);
    chk("f3_011_valid", 32'(resp_valid), 1);
    chk("f3_011_funct3", 32'(mem_funct3), 3);
    tick();
    req_valid = 1'b0;

`ifndef MISALIGN_TRAP_EN
    poke(9'h010, 32'h44332211);
    poke(9'h014, 32'h88776655);
    req_valid = 1'b1;
    req_read = 1'b0;
    req_write = 1'b1;
    req_addr = 9'h011;
    req_funct3 = 3'b010;
    req_wdata = 32'hAABBCCDD;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_split_stall", 32'(stall), 1);
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_split_write", 32'(mem_write), 0);
    chk("rst_split_stall0", 32'(stall), 0);
    chk("rst_split_valid", 32'(resp_valid), 0);
    tick();
    reset = 1'b0;
    req_valid = 1'b0;
    ref_mem[9'h011] = 8'hDD;
    ref_mem[9'h012] = 8'hCC;
    cnt_m = 0;
    chk("rst_split_count", 32'(misalign_count), 0);
    xact(1, 0, 9'h010, 3'b010, 0);
    chk("rst_split_lo", last_rd, 32'h44CCDD11);
    xact(1, 0, 9'h014, 3'b010, 0);
    chk("rst_split_hi", last_rd, 32'h88776655);

    req_valid = 1'b1;
    req_read = 1'b0;
    req_write = 1'b1;
    req_addr = 9'h101;
    req_funct3 = 3'b010;
    req_wdata = 32'h11223344;
    tick();
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("drop_stall", 32'(stall), 0);
    chk("drop_valid", 32'(resp_valid), 0);
    chk("drop_write", 32'(mem_write), 0);
    tick();
    ref_mem[9'h101] = 8'h44;
    ref_mem[9'h102] = 8'h33;
    cnt_m++;
    chk("drop_count", 32'(misalign_count), cnt_m);
    xact(1, 0, 9'h100, 3'b010, 0);
`endif

    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 2) xact(0, 1, 9'($urandom_range(0, 511)), lf3[$urandom_range(0, 2)], $urandom);
      else xact(1, r == 3, 9'($urandom_range(0, 511)), lf3[$urandom_range(0, 4)], $urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end

    bad = 0;
    for (int i = 0; i < 512; i++) if (dmem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
